// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request, response and
// program-load write channels, grouped so the fetch stage and loader connect
// through one port.
//   slave  : the responder (drives req_ready_o and the rsp_* outputs)
//   master : the fetch stage / loader (drives req_*, rsp_ready_i and wr_*)
interface imem_responder_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  // request channel (fetch PC)
  logic              req_valid_i;
  logic              req_ready_o;
  logic [AWIDTH-1:0] req_addr_i;
  // response channel (instruction word)
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DWIDTH-1:0] rsp_data_o;
  logic              rsp_err_o;
  // program-load write channel
  logic              wr_en_i;
  logic [AWIDTH-1:0] wr_addr_i;
  logic [DWIDTH-1:0] wr_data_i;

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, wr_en_i, wr_addr_i, wr_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: serves PC-addressed fetches from a word store at BASEADDR.
// Latency: rsp_valid_o follows an accept by LATENCY cycles (1 = the cycle right after accept).
// Backpressure: one request outstanding; response held stable while rsp_ready_i is low.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset (FSM and response registers only)
//   bus  - imem_responder_if.slave: req_valid_i/req_ready_o/req_addr_i,
//          rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_err_o, wr_en_i/wr_addr_i/wr_data_i
module imem_responder #(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       LATENCY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  imem_responder_if.slave  bus
);

  localparam int unsigned IWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Bounds are compared one bit wider than the address so that a store
  // ending at the top of the address space does not wrap to zero.
  localparam logic [AWIDTH:0] ADDR_LO = {1'b0, BASEADDR};
  localparam logic [AWIDTH:0] ADDR_HI = ADDR_LO + (AWIDTH+1)'(4 * DEPTH);

  // Counter preload: the WAIT state lasts LATENCY-1 cycles, entered with
  // LATENCY-2 and leaving on the cycle it sits at zero.
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [IWIDTH-1:0] lat_idx_q;
  logic              lat_err_q;
  logic [DWIDTH-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              req_rdy;
  logic              accept;
  logic              rsp_hs;
  logic              acc_err;
  logic [IWIDTH-1:0] acc_idx;
  logic              src_err;
  logic [IWIDTH-1:0] src_idx;
  logic              load_rsp;
  logic              wr_ok;
  logic [IWIDTH-1:0] wr_idx;

  // Instruction store; deliberately left out of reset so a program image
  // loaded before a reset pulse survives it.
  logic [DWIDTH-1:0] mem [DEPTH];

  // Misaligned, below the base, or at/after the end of the store.
  function automatic logic addr_bad(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] ax;
    ax = {1'b0, a};
    return (a[1:0] != 2'b00) || (ax < ADDR_LO) || (ax >= ADDR_HI);
  endfunction

  // Word index of a byte address; only meaningful when addr_bad() is 0.
  function automatic logic [IWIDTH-1:0] addr_idx(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] off;
    off = a - BASEADDR;
    return IWIDTH'(off >> 2);
  endfunction

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  // A new request may be taken in RESP only when the current response is
  // leaving on the same edge; this keeps a single request outstanding.
  assign req_rdy = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready_i);
  assign accept  = bus.req_valid_i && req_rdy;
  assign rsp_hs  = (state_q == RESP) && bus.rsp_ready_i;

  assign acc_err = addr_bad(bus.req_addr_i);
  assign acc_idx = addr_idx(bus.req_addr_i);

  // With single-cycle latency the store is read on the accept edge itself
  // from the live address; otherwise it is read from the latched request on
  // the edge that leaves WAIT.
  assign src_err  = (LATENCY == 1) ? acc_err : lat_err_q;
  assign src_idx  = (LATENCY == 1) ? acc_idx : lat_idx_q;
  assign load_rsp = (LATENCY == 1) ? accept
                                   : ((state_q == WAIT) && (cnt_q == 3'd0));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end else if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.req_ready_o = req_rdy;
    bus.rsp_valid_o = (state_q == RESP);
  end

  assign bus.rsp_data_o = rsp_data_q;
  assign bus.rsp_err_o  = rsp_err_q;

  // ---------------------------------------------------------------------
  // Request latch, latency counter and response registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      lat_idx_q  <= '0;
      lat_err_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        lat_idx_q <= acc_idx;
        lat_err_q <= acc_err;
        cnt_q     <= CNT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end

      // Outside load_rsp the registers keep their value, which is what
      // holds the response steady under backpressure.
      if (load_rsp) begin
        rsp_err_q <= src_err;
        if (src_err) begin
          rsp_data_q <= '0;
        end else begin
          rsp_data_q <= mem[src_idx];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Program-load write port
  // ---------------------------------------------------------------------
  // Range-checked like a fetch: an out-of-range address would otherwise
  // alias onto a low word after index truncation. A fetch of the same word
  // on the same edge sees the old contents (non-blocking update).
  assign wr_ok  = bus.wr_en_i && !rst && !addr_bad(bus.wr_addr_i);
  assign wr_idx = addr_idx(bus.wr_addr_i);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= bus.wr_data_i;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at LATENCY=1 and one at
// LATENCY=3, each on its own interface and reset.
module tb_imem_responder;

  logic clk;
  logic rst1;
  logic rst3;
  int   checks = 0;
  int   errors = 0;

  imem_responder_if #(.AWIDTH(32), .DWIDTH(32)) b1 ();
  imem_responder_if #(.AWIDTH(32), .DWIDTH(32)) b3 ();

  imem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
  imem_responder #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d);
    b1.wr_en_i = 1'b1; b1.wr_addr_i = a; b1.wr_data_i = d;
    tick();
    b1.wr_en_i = 1'b0;
  endtask

  task automatic wr3(input logic [31:0] a, input logic [31:0] d);
    b3.wr_en_i = 1'b1; b3.wr_addr_i = a; b3.wr_data_i = d;
    tick();
    b3.wr_en_i = 1'b0;
  endtask

  initial begin
    b1.req_valid_i = 1'b0; b1.req_addr_i = '0; b1.rsp_ready_i = 1'b1;
    b1.wr_en_i = 1'b0; b1.wr_addr_i = '0; b1.wr_data_i = '0;
    b3.req_valid_i = 1'b0; b3.req_addr_i = '0; b3.rsp_ready_i = 1'b1;
    b3.wr_en_i = 1'b0; b3.wr_addr_i = '0; b3.wr_data_i = '0;
    rst1 = 1'b1; rst3 = 1'b1;

    // ---- reset ----
    tick(); tick();
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_valid", 64'(b1.rsp_valid_o), 64'd0);
    chk("rst_err",   64'(b1.rsp_err_o),   64'd0);
    chk("rst_data",  64'(b1.rsp_data_o),  64'd0);
    chk("rst_ready", 64'(b1.req_ready_o), 64'd1);
    chk("rst3_valid", 64'(b3.rsp_valid_o), 64'd0);
    chk("rst3_ready", 64'(b3.req_ready_o), 64'd1);

    // ---- single fetch, LATENCY=1 ----
    wr1(32'h01000000, 32'h00500093);
    b1.req_valid_i = 1'b1; b1.req_addr_i = 32'h01000000;
    tick();
    b1.req_valid_i = 1'b0;
    chk("single_valid", 64'(b1.rsp_valid_o), 64'd1);
    chk("single_data",  64'(b1.rsp_data_o),  64'h00500093);
    chk("single_err",   64'(b1.rsp_err_o),   64'd0);
    tick();
    chk("single_drop", 64'(b1.rsp_valid_o), 64'd0);

    // ---- streaming, one response per cycle ----
    wr1(32'h01000000, 32'h11);
    wr1(32'h01000004, 32'h22);
    wr1(32'h01000008, 32'h33);
    b1.req_valid_i = 1'b1; b1.req_addr_i = 32'h01000000;
    chk("stream_rdy0", 64'(b1.req_ready_o), 64'd1);
    tick();
    b1.req_addr_i = 32'h01000004;
    chk("stream_d0",   64'(b1.rsp_data_o),  64'h11);
    chk("stream_v0",   64'(b1.rsp_valid_o), 64'd1);
    chk("stream_rdy1", 64'(b1.req_ready_o), 64'd1);
    tick();
    b1.req_addr_i = 32'h01000008;
    chk("stream_d1",   64'(b1.rsp_data_o),  64'h22);
    chk("stream_rdy2", 64'(b1.req_ready_o), 64'd1);
    tick();
    b1.req_valid_i = 1'b0;
    chk("stream_d2", 64'(b1.rsp_data_o),  64'h33);
    chk("stream_v2", 64'(b1.rsp_valid_o), 64'd1);
    tick();
    chk("stream_end", 64'(b1.rsp_valid_o), 64'd0);

    // ---- backpressure: stall 3 cycles, then handshake + accept same edge ----
    b1.rsp_ready_i = 1'b0;
    b1.req_valid_i = 1'b1; b1.req_addr_i = 32'h01000004;
    tick();
    b1.req_addr_i = 32'h01000008;
    chk("bp_ready_stall", 64'(b1.req_ready_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data",  64'(b1.rsp_data_o),  64'h22);
      chk("bp_hold_valid", 64'(b1.rsp_valid_o), 64'd1);
      chk("bp_hold_ready", 64'(b1.req_ready_o), 64'd0);
    end
    b1.rsp_ready_i = 1'b1;
    #1;
    chk("bp_ready_release", 64'(b1.req_ready_o), 64'd1);
    tick();
    b1.req_valid_i = 1'b0;
    chk("bp_next_valid", 64'(b1.rsp_valid_o), 64'd1);
    chk("bp_next_data",  64'(b1.rsp_data_o),  64'h33);
    tick();
    chk("bp_end", 64'(b1.rsp_valid_o), 64'd0);

    // ---- error cases and range boundaries ----
    wr1(32'h01000FFC, 32'hCAFEF00D);
    wr1(32'h01001000, 32'hDEADBEEF);
    b1.req_valid_i = 1'b1; b1.req_addr_i = 32'h01000002;
    tick();
    b1.req_addr_i = 32'h00FFFFFC;
    chk("err_misal_valid", 64'(b1.rsp_valid_o), 64'd1);
    chk("err_misal_err",   64'(b1.rsp_err_o),   64'd1);
    chk("err_misal_data",  64'(b1.rsp_data_o),  64'd0);
    tick();
    b1.req_addr_i = 32'h01001000;
    chk("err_below_err",  64'(b1.rsp_err_o),  64'd1);
    chk("err_below_data", 64'(b1.rsp_data_o), 64'd0);
    tick();
    b1.req_addr_i = 32'h01000FFC;
    chk("err_above_err",  64'(b1.rsp_err_o),  64'd1);
    chk("err_above_data", 64'(b1.rsp_data_o), 64'd0);
    tick();
    b1.req_addr_i = 32'h01000000;
    chk("last_word_err",  64'(b1.rsp_err_o),  64'd0);
    chk("last_word_data", 64'(b1.rsp_data_o), 64'hCAFEF00D);
    tick();
    chk("oob_write_ignored", 64'(b1.rsp_data_o), 64'h11);
    chk("oob_write_err",     64'(b1.rsp_err_o),  64'd0);

    // ---- read-before-write on the same word and edge ----
    b1.req_addr_i = 32'h01000004;
    b1.wr_en_i = 1'b1; b1.wr_addr_i = 32'h01000004; b1.wr_data_i = 32'h44;
    tick();
    b1.wr_en_i = 1'b0;
    chk("rbw_old", 64'(b1.rsp_data_o), 64'h22);
    tick();
    b1.req_valid_i = 1'b0;
    chk("rbw_new", 64'(b1.rsp_data_o), 64'h44);
    tick();
    chk("rbw_end", 64'(b1.rsp_valid_o), 64'd0);

    // ---- LATENCY=3: 1 accept cycle + 2 WAIT cycles, valid after 2nd edge ----
    wr3(32'h01000000, 32'hA5A5A5A5);
    wr3(32'h01000004, 32'h5A5A5A5A);
    b3.req_valid_i = 1'b1; b3.req_addr_i = 32'h01000000;
    tick();
    b3.req_valid_i = 1'b0;
    chk("l3_e0_valid", 64'(b3.rsp_valid_o), 64'd0);
    chk("l3_wait_rdy", 64'(b3.req_ready_o), 64'd0);
    tick();
    chk("l3_e1_valid", 64'(b3.rsp_valid_o), 64'd0);
    tick();
    chk("l3_e2_valid", 64'(b3.rsp_valid_o), 64'd1);
    chk("l3_e2_data",  64'(b3.rsp_data_o),  64'hA5A5A5A5);
    chk("l3_e2_err",   64'(b3.rsp_err_o),   64'd0);
    tick();
    chk("l3_drop", 64'(b3.rsp_valid_o), 64'd0);

    // second request, reset one cycle after its accept (mid-WAIT)
    b3.req_valid_i = 1'b1; b3.req_addr_i = 32'h01000004;
    tick();
    b3.req_valid_i = 1'b0;
    tick();
    rst3 = 1'b1;
    #1;
    chk("l3_rst_valid", 64'(b3.rsp_valid_o), 64'd0);
    chk("l3_rst_data",  64'(b3.rsp_data_o),  64'd0);
    tick(); tick();
    rst3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l3_no_stale", 64'(b3.rsp_valid_o), 64'd0);
    end

    // fresh request after reset; memory survives reset
    b3.req_valid_i = 1'b1; b3.req_addr_i = 32'h01000004;
    tick();
    b3.req_valid_i = 1'b0;
    chk("l3_fresh_e0", 64'(b3.rsp_valid_o), 64'd0);
    tick();
    chk("l3_fresh_e1", 64'(b3.rsp_valid_o), 64'd0);
    tick();
    chk("l3_fresh_valid", 64'(b3.rsp_valid_o), 64'd1);
    chk("l3_fresh_data",  64'(b3.rsp_data_o),  64'h5A5A5A5A);
    chk("l3_fresh_err",   64'(b3.rsp_err_o),   64'd0);
    tick();
    chk("l3_fresh_drop", 64'(b3.rsp_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
